// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: arbiter state encoding, RAM geometry defaults, T-state count.
// Latency: none (types and constants only).
// Backpressure: n/a.
package sap1_pkg;

    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_DRAIN = 2'd1,
        S_LD    = 2'd2,
        S_RET   = 2'd3
    } arb_state_t;

    localparam int SAP_AW   = 4;
    localparam int SAP_DW   = 8;
    // One instruction is T0..T6.
    localparam int T_STATES = 7;

endpackage

// File: rtl/arbitro_ram.sv
// Shares the single SAP-1 program/data RAM port between the control unit and a program loader.
// Latency: loader access is performed in the cycle ld_req is seen in S_LD; ld_ack/ld_rdata follow one cycle later.
// Backpressure: loader waits (ld_req held) until an instruction boundary; CPU is frozen via cpu_stall only at T0.
module arbitro_ram
    import sap1_pkg::*;
#(
    parameter int AW        = SAP_AW,
    parameter int DW        = SAP_DW,
    parameter int MAX_BURST = 16,
    parameter int GUARD     = T_STATES
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_boundary,
    output logic          cpu_stall,
    output logic          cpu_gnt,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ld_busy
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int GW = $clog2(GUARD + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);

    arb_state_t    state;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] guard_cnt;
    logic          cap_exit;   // current burst ended on the cap, so arm the guard window
    logic          ld_access;  // loader performs a RAM access this cycle
    logic          grant_now;  // loader is being granted at this T0

    // Port ownership, same-cycle stall on grant, and the RAM mux. Reset suppresses any
    // grant or loader access so a held ld_req can neither stall the CPU nor write RAM.
    always_comb begin
        ld_busy   = (state == S_LD) || (state == S_RET);
        cpu_gnt   = !ld_busy;
        ld_access = (state == S_LD) && ld_req && !CLR;
        grant_now = ld_req && !CLR && cpu_boundary &&
                    (((state == S_CPU) && (guard_cnt == '0)) || (state == S_DRAIN));
        cpu_stall = ld_busy || grant_now;
        ram_addr  = cpu_gnt ? cpu_addr : ld_addr;
        ram_ce    = cpu_gnt ? cpu_req : ld_access;
        ram_we    = ld_access && ld_we;
        ram_wdata = (state == S_LD) ? ld_wdata : '0;
    end

    // Arbitration FSM, burst/guard counters and the registered loader response.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= S_CPU;
            burst_cnt <= '0;
            guard_cnt <= '0;
            cap_exit  <= 1'b0;
            ld_ack    <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_ack <= ld_access;
            if (ld_access && !ld_we) begin
                ld_rdata <= ram_rdata;
            end

            case (state)
                S_CPU: begin
                    if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                    if (ld_req && (guard_cnt == '0)) begin
                        state <= cpu_boundary ? S_LD : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Let the CPU finish its instruction; abandon if the loader gives up.
                    if (!ld_req) begin
                        state <= S_CPU;
                    end else if (cpu_boundary) begin
                        state <= S_LD;
                    end
                end
                S_LD: begin
                    if (ld_access) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                    if (!ld_req) begin
                        state    <= S_RET;
                        cap_exit <= 1'b0;
                    end else if (burst_cnt == BURST_LAST) begin
                        state    <= S_RET;
                        cap_exit <= 1'b1;
                    end
                end
                S_RET: begin
                    // Turnaround: last ack goes out here, port returns to the CPU.
                    state     <= S_CPU;
                    burst_cnt <= '0;
                    guard_cnt <= cap_exit ? GUARD_LOAD : '0;
                    cap_exit  <= 1'b0;
                end
                default: state <= S_CPU;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_ram.sv
// Bench for arbitro_ram: directed scenarios followed by randomized loader traffic.
// Reference: in-order loader op queue plus a shadow memory; each ack retires the oldest op.
// A small T-state counter stands in for the SAP-1 control unit and obeys cpu_stall.
module tb_arbitro_ram;
    import sap1_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       cpu_req;
    logic [3:0] cpu_addr = '0;
    logic       cpu_boundary;
    logic       cpu_stall, cpu_gnt;
    logic       ld_req = 1'b1;
    logic       ld_we = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_wdata = '0;
    logic       ld_ack;
    logic [7:0] ld_rdata;
    logic       ram_ce, ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic       ld_busy;

    arbitro_ram #(.AW(4), .DW(8), .MAX_BURST(16), .GUARD(7)) dut (
        .CLK(CLK), .CLR(CLR),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_boundary(cpu_boundary),
        .cpu_stall(cpu_stall), .cpu_gnt(cpu_gnt),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ld_busy(ld_busy)
    );

    always #5 CLK = ~CLK;

    // Environment: control unit T-state counter and the asynchronous-read RAM.
    logic [2:0] t_state;
    logic [7:0] mem [16];
    logic [7:0] init_mem [16];
    bit         preload = 1'b1;

    assign ram_rdata    = mem[ram_addr];
    assign cpu_boundary = (t_state == 3'd0);
    assign cpu_req      = (t_state == 3'd1) || (t_state == 3'd3);

    always @(posedge CLK) begin
        if (CLR) t_state <= 3'd0;
        else if (!cpu_stall) t_state <= (t_state == 3'd6) ? 3'd0 : 3'(t_state + 3'd1);
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else if (ram_ce && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    op_t        ops[$];
    logic [7:0] ref_mem [16];
    int checks = 0, errors = 0, acks = 0, cyc = 0;
    bit mon_on = 1'b0, ld_hold = 1'b1, clr_next = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: retire acked op, drive inputs at the negedge, then check invariants.
    task automatic tick();
        op_t o;
        @(negedge CLK);
        cyc++;
        if (ld_ack === 1'b1) begin
            check("ack_has_pending_op", ops.size() > 0, 1);
            if (ops.size() > 0) begin
                o = ops.pop_front();
                if (o.we) ref_mem[o.addr] = o.data;
                else check("ld_rdata", ld_rdata, ref_mem[o.addr]);
                acks++;
            end
        end
        CLR      = clr_next;
        cpu_addr = 4'($urandom_range(0, 15));
        if (ops.size() > 0) begin
            ld_req   = 1'b1;
            ld_we    = ops[0].we;
            ld_addr  = ops[0].addr;
            ld_wdata = ops[0].data;
        end else begin
            ld_req   = ld_hold;
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 4'($urandom_range(0, 15));
            ld_wdata = 8'($urandom_range(0, 255));
        end
        #1;
        if (mon_on) begin
            check("stall_only_at_t0", cpu_stall && (t_state != 3'd0), 0);
            check("single_owner", cpu_gnt ^ ld_busy, 1);
            check("no_write_while_cpu_owns", cpu_gnt && ram_we, 0);
        end
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n = 0;
        while ((ops.size() > 0 || ld_busy) && n < budget) begin
            tick();
            n++;
        end
        check(tag, (ops.size() > 0) || ld_busy, 0);
    endtask

    task automatic push(input logic we, input logic [3:0] addr, input logic [7:0] data);
        op_t o;
        o.we = we; o.addr = addr; o.data = data;
        ops.push_back(o);
    endtask

    initial begin
        int n, acks0, acc_cyc, nostall;
        for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom_range(0, 255));
        init_mem[3] = 8'h1C;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];

        // 1: reset held 3 cycles with ld_req high at a boundary
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_cpu_gnt", cpu_gnt, 1);
            check("rst_ld_ack", ld_ack, 0);
            check("rst_cpu_stall", cpu_stall, 0);
            check("rst_ld_busy", ld_busy, 0);
        end
        clr_next = 1'b0;
        ld_hold  = 1'b0;
        preload  = 1'b0;
        tick();
        mon_on = 1'b1;

        // 2: write 0xA7 to 0x5 requested at T3
        n = 0;
        while (t_state != 3'd2 && n < 20) begin tick(); n++; end
        check("t2_reach_t2", t_state, 2);
        push(1'b1, 4'h5, 8'hA7);
        tick();
        check("t2_drain_no_stall", cpu_stall, 0);
        check("t2_drain_cpu_gnt", cpu_gnt, 1);
        n = 0;
        do begin tick(); n++; end while (!cpu_stall && n < 20);
        check("t2_cycles_to_grant", n, 4);
        check("t2_grant_at_t0", t_state, 0);
        tick();
        check("t2_ram_we", ram_we, 1);
        check("t2_ram_addr", ram_addr, 4'h5);
        check("t2_ram_wdata", ram_wdata, 8'hA7);
        check("t2_cpu_gnt_off", cpu_gnt, 0);
        tick();
        check("t2_ack", ld_ack, 1);
        check("t2_mem5", mem[5], 8'hA7);
        tick();
        check("t2_ret_stall", cpu_stall, 1);
        check("t2_ret_ce", ram_ce, 0);
        check("t2_ret_busy", ld_busy, 1);
        tick();
        check("t2_resume_stall", cpu_stall, 0);
        check("t2_resume_t0", t_state, 0);
        check("t2_resume_gnt", cpu_gnt, 1);

        // 3: read of 0x3 (0x1C), ack exactly one cycle after the access
        push(1'b0, 4'h3, 8'h00);
        acc_cyc = -100;
        n = 0;
        do begin
            tick(); n++;
            if (ram_ce && !ram_we && !cpu_gnt) acc_cyc = cyc;
        end while (ld_ack !== 1'b1 && n < 30);
        check("t3_ack_seen", ld_ack, 1);
        check("t3_ack_latency", cyc - acc_cyc, 1);
        check("t3_rdata", ld_rdata, 8'h1C);
        run_idle("t3_idle", 20);

        // 4: 20 back-to-back writes; cap at 16, guard window, then the rest
        acks0 = acks;
        for (int i = 0; i < 20; i++) push(1'b1, 4'($urandom_range(0, 15)), 8'(i * 11 + 3));
        n = 0;
        while (!ld_busy && n < 20) begin tick(); n++; end
        check("t4_granted", ld_busy, 1);
        n = 0;
        while (ld_busy && n < 40) begin tick(); n++; end
        check("t4_acks_first_burst", acks - acks0, 16);
        check("t4_ops_left", ops.size(), 4);
        check("t4_exit_t0", t_state, 0);
        nostall = (cpu_stall == 1'b0) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!cpu_stall && cpu_gnt) nostall++;
        end
        check("t4_guard_cycles", nostall, 7);
        tick();
        check("t4_regrant_t0", t_state, 0);
        check("t4_regrant_stall", cpu_stall, 1);
        run_idle("t4_idle", 40);
        check("t4_acks_total", acks - acks0, 20);

        // 5: request arriving exactly at the boundary with cpu_req low
        n = 0;
        while (t_state != 3'd6 && n < 20) begin tick(); n++; end
        push(1'b0, 4'($urandom_range(0, 15)), 8'h00);
        tick();
        check("t5_boundary", t_state, 0);
        check("t5_cpu_req_low_ce", ram_ce, 0);
        check("t5_same_cycle_stall", cpu_stall, 1);
        tick();
        check("t5_t0_held", t_state, 0);
        run_idle("t5_idle", 20);

        // 6: reset during access 3 of 5
        acks0 = acks;
        for (int i = 0; i < 5; i++) push(1'b1, 4'(8 + i), ~ref_mem[8 + i]);
        n = 0;
        while (!ld_busy && n < 20) begin tick(); n++; end
        check("t6_granted", ld_busy, 1);
        tick();
        clr_next = 1'b1;
        tick();
        check("t6_clr_no_we", ram_we, 0);
        check("t6_ack_of_access2", ld_ack, 1);
        ops.delete();
        clr_next = 1'b0;
        tick();
        check("t6_no_ack", ld_ack, 0);
        check("t6_ram_we", ram_we, 0);
        check("t6_cpu_gnt", cpu_gnt, 1);
        check("t6_cpu_stall", cpu_stall, 0);
        check("t6_ld_busy", ld_busy, 0);
        check("t6_acks", acks - acks0, 2);
        check("t6_aborted_write", mem[10], ref_mem[10]);

        // Randomized traffic: mixed reads/writes, bursts of up to 20 ops
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 10);
            for (int g = 0; g < n; g++) tick();
            acks0 = acks;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++)
                push(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            run_idle("rnd_idle", 200);
            check("rnd_ack_count", acks - acks0, n);
        end

        tick();
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_ram.md
Name: arbitro_ram

Overview:
- Arbitrates the single 16x8 program/data RAM port between two requesters: the SAP-1 control unit (fetch/execute) and an external program loader (manual/serial load path).
- The CPU owns the port by default.
- The loader is granted only at an instruction boundary (T0). While the loader holds the port, the control unit's T-state counter is frozen through `cpu_stall`.
- A burst cap plus a guard window guarantee CPU forward progress.

Parameters:
- AW, 4, RAM address width.
- DW, 8, RAM data width.
- MAX_BURST, 16, maximum loader accesses per grant before forced yield.
- GUARD, 7, cycles after yield during which `ld_req` is ignored (one full T0..T6 instruction).

Ports:
- CLK  in  1  system clock
- CLR  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU RAM access this cycle (the CE phase)
- cpu_addr  in  AW  CPU address (from MAR)
- cpu_boundary  in  1  control unit is in T0 (safe stall point)
- cpu_stall  out  1  freeze T-state counter and PC
- cpu_gnt  out  1  CPU currently owns RAM port
- ld_req  in  1  loader access request (level, held until ack)
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_ack  out  1  one-cycle pulse: access done
- ld_rdata  out  DW  registered read data, valid with ld_ack
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data (asynchronous read)
- ld_busy  out  1  loader owns the port (S_LD or S_RET)

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset CLR is synchronous and active-high.
  - On reset: state = S_CPU; burst_cnt = 0; guard_cnt = 0; ld_ack = 0; ld_rdata = 0.
  - Reset mid-burst aborts the access. No ack is issued, and ram_we is 0 in the cycle after reset.
- States: S_CPU, S_DRAIN, S_LD, S_RET.
- S_CPU:
  - ram_addr = cpu_addr; ram_ce = cpu_req; ram_we = 0; cpu_gnt = 1.
  - If ld_req && guard_cnt == 0 && cpu_boundary: go to S_LD, and cpu_stall = 1 combinationally in this same cycle so T0 holds.
  - If ld_req && guard_cnt == 0 && !cpu_boundary: go to S_DRAIN.
- S_DRAIN:
  - Same port muxing as S_CPU; the CPU finishes its instruction.
  - On cpu_boundary: cpu_stall = 1 combinationally and go to S_LD.
  - If ld_req drops: return to S_CPU.
- S_LD:
  - cpu_stall = 1; cpu_gnt = 0; ram_addr = ld_addr; ram_wdata = ld_wdata; ram_ce = ld_req; ram_we = ld_req & ld_we.
  - Each cycle with ld_req performs one access. The next cycle, ld_ack = 1 and, for reads, ld_rdata <= ram_rdata sampled in the access cycle. Latency is one cycle.
  - burst_cnt increments per access.
  - Go to S_RET when ld_req is low, or when burst_cnt reaches MAX_BURST-1 on an access.
  - Loader protocol: after ack the loader may hold ld_req high with a new address or data. That is the next access; back-to-back throughput is one access per cycle.
- S_RET:
  - One turnaround cycle: cpu_stall = 1; ram_ce = 0; the ack of the last access is issued here.
  - Then go to S_CPU with burst_cnt = 0.
  - guard_cnt = GUARD if exit was due to the burst cap, else 0.
- guard_cnt decrements every cycle in S_CPU while nonzero, saturating at 0.
- cpu_stall is 0 in S_CPU/S_DRAIN except on the grant cycle defined above.
- The CPU is never stalled outside T0. The RAM is never driven by both requesters in one cycle.
- ld_busy = (state == S_LD || state == S_RET).
- Widths: burst_cnt is clog2(MAX_BURST) + 1 bits and guard_cnt is clog2(GUARD + 1) bits. Neither counter wraps.

Decomposition:
- Shared package (sap1_pkg) holds:
  - state encoding (S_CPU = 0, S_DRAIN = 1, S_LD = 2, S_RET = 3);
  - AW/DW defaults;
  - T-state count 7.
- No sub-module. The FSM, the two counters and the port mux fit in one module.

Test Plan:
1. CLR held 3 cycles with ld_req = 1 -> state S_CPU, cpu_gnt = 1, ld_ack = 0, cpu_stall = 0 throughout.
2. CPU running, ld_req asserted at T3 for write addr 0x5, data 0xA7 -> S_DRAIN until cpu_boundary.
   - Stall is asserted at T0, and ram_we = 1 with addr 0x5 the next cycle.
   - ld_ack follows one cycle later; mem[5] = 0xA7.
   - CPU resumes at T0 after the S_RET cycle.
3. Loader read of addr 0x3, where mem[3] = 0x1C -> ld_ack with ld_rdata = 0x1C, exactly one cycle after the access cycle.
4. Loader holds ld_req for 20 back-to-back writes -> exactly 16 acks, then S_RET.
   - ld_req is ignored for 7 cycles, and the CPU completes one instruction.
   - The remaining 4 writes complete on the next boundary grant.
5. ld_req at cpu_boundary with cpu_req = 0 -> same-cycle cpu_stall = 1, and the T-state counter reads T0 on the next edge.
6. CLR pulsed mid-burst (access 3 of 5) -> no ack for that access, ram_we = 0, state S_CPU, cpu_stall = 0 on the following cycle.
